seq_detect_moore: RTL
=====================

# seq_detect_moore

Parametrised Moore-type serial sequence detector: matches a runtime-programmable PAT_W-bit pattern on a 1-bit serial input. It supports overlapping and non-overlapping match modes, a sample-enable qualifier and a saturating match counter. It sits on serial bit streams (line decoders, frame-sync search) and replaces the team's fixed-pattern 3-bit detectors; PAT_W=3, PAT_RST=3'b101, OVERLAP=0 gives the classic "101" behaviour.

## Interface
- PAT_W, 4, pattern length in bits, legal 2..16
- PAT_RST, 4'b1011, pattern register value after reset, PAT_W bits
- OVERLAP, 1, 1 = overlapping matches allowed, 0 = detector restarts from empty after a match
- CNT_W, 8, match counter width, legal 1..32
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  sample qualifier; x is consumed only on cycles with en=1
- x  in  1  serial data bit
- pat_load  in  1  load pat_in into the pattern register
- pat_in  in  PAT_W  new pattern; bit PAT_W-1 is the first bit expected on x
- cnt_clr  in  1  synchronous clear of match_cnt
- y  out  1  Moore match flag, high while state == PAT_W
- state  out  $clog2(PAT_W+1)  current matched-prefix length, for debug/observation
- match_cnt  out  CNT_W  number of matches, saturating

## Operation
- State s, range 0..PAT_W, holds the length of the longest pattern prefix that is a suffix of the bits consumed since the last restart.
- Prefix of length k means pat[PAT_W-1 -: k].
- Next state when en=1, pattern string P:
  - s < PAT_W: nxt = largest k ≤ s+1 such that P[0..k-1] == suffix of (P[0..s-1], x). This is the KMP transition; it needs no history register.
  - s == PAT_W, OVERLAP=1: same rule applied to (P, x), with k limited to ≤ PAT_W.
  - s == PAT_W, OVERLAP=0: nxt = (x == P[0]) ? 1 : 0.
- en=0: s holds and x is ignored.
- pat_load=1: the pattern register takes pat_in and s goes to 0. This has priority over en in the same cycle.
- y = (s == PAT_W). It depends only on registered state, never on x.
- match_cnt:
  - increments by 1 on any en cycle whose nxt == PAT_W, provided pat_load=0;
  - saturates at 2^CNT_W-1;
  - cnt_clr=1 forces 0, and clear wins over a same-cycle increment;
  - pat_load does not affect match_cnt.

## Timing
- Reset (rst=0, asynchronous):
  - s = 0, y = 0, match_cnt = 0, pattern register = PAT_RST.
  - Deassertion is synchronous to clk and handled externally.
- Latency: the final pattern bit is sampled at edge N, and y is high in the cycle after edge N.
- y stays high for one enabled sample. With en=0 after a match, y stays high until the next enabled sample.
- Back-to-back matches (OVERLAP=1 with a self-overlapping pattern) can hold y high on consecutive cycles, e.g. pattern 1111 on stream 11111.
- Reset mid-pattern discards the partial match. The first match after reset needs a full PAT_W fresh bits.
- A pat_load while y=1 drops y on the next cycle.

## Structure
- Package seq_detect_pkg holds:
  - function state_w(PAT_W) returning $clog2(PAT_W+1);
  - function prefix_match(pat, s, x, k) used by the next-state search;
  - the parameter legality checks, as elaboration-time assertions.
- Sub-module seq_detect_next: purely combinational next-state function.
  - Inputs: pattern, s, x, OVERLAP.
  - Output: nxt.
  - Implemented as a loop over k from high to low with first-hit priority.
- The top level holds the state register, pattern register, counter and enable/load priority.

## Test plan
- Overlap mode (defaults, pattern 1011), en=1, stream 1,0,1,1,0,1,1,1,0 → states 1,2,3,4,2,3,4,1,2; y high after bits 4 and 7; match_cnt=2.
- Same stream with OVERLAP=0 → states 1,2,3,4,0,1,1,1,2; one y pulse; match_cnt=1.
- en gaps: stream 1011 with en=0 on alternate cycles → y asserts only after the 4th enabled sample and holds through the following en=0 cycles; match_cnt=1.
- Runtime load: pat_load with pat_in=4'b0110 in mid-match (s=3) → s=0 next cycle; stream 0110 → match; old pattern 1011 no longer matches; match_cnt is unchanged by the load itself.
- Counter: CNT_W=2, pattern 1111, OVERLAP=1, eight 1s → match_cnt 0,0,0,1,2,3,3,3. Then cnt_clr together with a match cycle → 0.
- Reset: assert rst=0 asynchronously at s=3 between edges → y=0, s=0, match_cnt=0 immediately. After release, the stream 011 does not match; the stream 1011 matches.

Source files
------------

// File: rtl/seq_detect_moore_pkg.sv
// Shared helpers for the serial sequence detector: state width, KMP prefix test,
// and parameter legality predicates.
package seq_detect_pkg;

  function automatic int unsigned state_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic bit pat_w_ok(input int unsigned pat_w);
    return (pat_w >= 2) && (pat_w <= 16);
  endfunction

  function automatic bit cnt_w_ok(input int unsigned cnt_w);
    return (cnt_w >= 1) && (cnt_w <= 32);
  endfunction

  // Pattern is MSB-aligned in 16 bits, so character i of the string is bit 15-i.
  function automatic logic pat_bit(input logic [15:0] pat, input int unsigned i);
    logic [15:0] t;
    t = pat << i;
    return t[15];
  endfunction

  // True when the length-k prefix equals the suffix of (P[0..s-1], x).
  function automatic logic prefix_match(input logic [15:0] pat, input int unsigned s,
                                        input logic x, input int unsigned k);
    logic ok;
    ok = 1'b1;
    if (k == 0) return 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if ((i + 1 < k) && (pat_bit(pat, i) != pat_bit(pat, s - k + 1 + i))) ok = 1'b0;
    end
    if (pat_bit(pat, k - 1) != x) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/seq_detect_moore_if.sv
// Control/data bundle for seq_detect_moore; master drives samples, slave is the detector.
interface seq_detect_moore_if
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned SW = state_w(PAT_W);

  logic             en;
  logic             x;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic             y;
  logic [SW-1:0]    state;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, x, pat_load, pat_in, cnt_clr,
    input  y, state, match_cnt
  );

  modport slave (
    input  en, x, pat_load, pat_in, cnt_clr,
    output y, state, match_cnt
  );
endinterface

// File: rtl/seq_detect_moore_next.sv
// Combinational KMP next-state: longest pattern prefix that is a suffix of (P[0..s-1], x).
module seq_detect_next
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W   = 4,
  parameter bit          OVERLAP = 1'b1
) (
  input  logic [PAT_W-1:0]          pattern,
  input  logic [state_w(PAT_W)-1:0] s,
  input  logic                      x,
  output logic [state_w(PAT_W)-1:0] nxt
);
  localparam int unsigned SW = state_w(PAT_W);
  localparam logic [SW-1:0] FULL = SW'(PAT_W);

  logic [15:0] pat16;
  logic        hit;

  always_comb begin
    pat16 = 16'(pattern) << (16 - PAT_W);
    nxt   = '0;
    hit   = 1'b0;
    if ((s == FULL) && !OVERLAP) begin
      nxt = (x == pattern[PAT_W-1]) ? SW'(1) : '0;
    end else begin
      // Scan k from PAT_W down to 0; the first (longest) hit wins, k=0 always hits.
      for (int unsigned j = 0; j <= PAT_W; j++) begin
        if (!hit && (PAT_W - j <= 32'(s) + 1) &&
            prefix_match(pat16, 32'(s), x, PAT_W - j)) begin
          nxt = SW'(PAT_W - j);
          hit = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/seq_detect_moore.sv
// Moore serial sequence detector with runtime pattern, overlap mode and saturating match count.
module seq_detect_moore
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011),
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detect_moore_if.slave bus
);
  localparam int unsigned SW = state_w(PAT_W);
  localparam logic [SW-1:0] FULL = SW'(PAT_W);

  if (!pat_w_ok(PAT_W)) begin : g_bad_pat_w
    $error("seq_detect_moore: PAT_W must be in 2..16");
  end
  if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
    $error("seq_detect_moore: CNT_W must be in 1..32");
  end

  logic [PAT_W-1:0] pat_q;
  logic [SW-1:0]    s_q;
  logic [SW-1:0]    nxt;
  logic [CNT_W-1:0] cnt_q;

  seq_detect_next #(
    .PAT_W   (PAT_W),
    .OVERLAP (OVERLAP)
  ) u_next (
    .pattern (pat_q),
    .s       (s_q),
    .x       (bus.x),
    .nxt     (nxt)
  );

  // pat_load overrides en and suppresses the count for that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= PAT_RST;
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (bus.pat_load) begin
        pat_q <= bus.pat_in;
        s_q   <= '0;
      end else if (bus.en) begin
        s_q <= nxt;
      end

      if (bus.cnt_clr)
        cnt_q <= '0;
      else if (bus.en && !bus.pat_load && (nxt == FULL) && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.y         = (s_q == FULL);
  assign bus.state     = s_q;
  assign bus.match_cnt = cnt_q;
endmodule
